// File: rtl/baby_alu_if.sv
// ==========================================================================
// Module  : baby_alu_if
// Purpose : Request/response bundle between the BabyBench driver/monitor and
//           the baby_alu responder. The drop_cnt signal exists only when
//           BABY_ALU_DROP_CNT_EN is defined.
// Revision: 1.0 - initial release
// ==========================================================================
`default_nettype none

interface baby_alu_if #(
  parameter int DATA_W = 8
`ifdef BABY_ALU_DROP_CNT_EN
  ,
  parameter int DROP_CNT_W = 8
`endif
);
  logic                  vld;
  logic [1:0]            op;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic [2*DATA_W-1:0]   out;
  logic                  ov;
  logic                  out_vld;
  logic                  busy;
`ifdef BABY_ALU_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
`endif

  modport master (
    output vld, op, a, b,
    input  out, ov, out_vld, busy
`ifdef BABY_ALU_DROP_CNT_EN
    ,
    input  drop_cnt
`endif
  );

  modport slave (
    input  vld, op, a, b,
    output out, ov, out_vld, busy
`ifdef BABY_ALU_DROP_CNT_EN
    ,
    output drop_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/baby_alu.sv
// ==========================================================================
// Module  : baby_alu
// Purpose : Add/sub/xor in one cycle, iterative shift-add multiply with BUSY.
//           Optional saturating dropped-request counter: BABY_ALU_DROP_CNT_EN.
// Revision: 1.0 - initial release
// ==========================================================================
`default_nettype none

module baby_alu #(
  parameter int DATA_W = 8
`ifdef BABY_ALU_DROP_CNT_EN
  ,
  parameter int DROP_CNT_W = 8
`endif
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  baby_alu_if.slave    bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t              state;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] out_q;
  logic                ov_q;
  logic                out_vld_q;

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] sum;
  logic [2*DATA_W-1:0] diff;
  logic [2*DATA_W-1:0] acc_next;

  assign a_ext    = {{DATA_W{1'b0}}, bus.a};
  assign b_ext    = {{DATA_W{1'b0}}, bus.b};
  assign sum      = a_ext + b_ext;
  // Wrapping in 2*DATA_W bits yields the sign-extended difference directly.
  assign diff     = a_ext - b_ext;
  // mcand is pre-shifted each step, so it already equals multiplicand << cnt.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  assign bus.busy    = (state == MUL);
  assign bus.out     = out_q;
  assign bus.ov      = ov_q;
  assign bus.out_vld = out_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_q     <= '0;
      ov_q      <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.vld) begin
            case (bus.op)
              OP_ADD: begin
                out_q     <= sum;
                ov_q      <= sum[DATA_W];
                out_vld_q <= 1'b1;
              end
              OP_SUB: begin
                out_q     <= diff;
                ov_q      <= (bus.a < bus.b);
                out_vld_q <= 1'b1;
              end
              OP_MUL: begin
                mcand  <= a_ext;
                mplier <= bus.b;
                acc    <= '0;
                cnt    <= '0;
                state  <= MUL;
              end
              default: begin
                out_q     <= {{DATA_W{1'b0}}, bus.a ^ bus.b};
                ov_q      <= 1'b0;
                out_vld_q <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            out_q     <= acc_next;
            ov_q      <= |acc_next[2*DATA_W-1:DATA_W];
            out_vld_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BABY_ALU_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  assign bus.drop_cnt = drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (bus.vld && (state == MUL) && !(&drop_cnt_q)) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_baby_alu.sv
// ==========================================================================
// Module  : tb_baby_alu
// Purpose : Directed self-checking bench for baby_alu with hand-computed
//           expected results.
// Revision: 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_baby_alu;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  baby_alu_if bus ();

  baby_alu u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb);
    bus.vld = v;
    bus.op  = o;
    bus.a   = aa;
    bus.b   = bb;
  endtask

  // Counts cycles with busy high (bounded) and whether out_vld leaked meanwhile.
  task automatic wait_mul(output int busy_cycles, output int early_vld);
    busy_cycles = 0;
    early_vld   = 0;
    while (bus.busy && busy_cycles < 40) begin
      if (bus.out_vld) early_vld++;
      busy_cycles++;
      tick();
    end
  endtask

  int bc;
  int ev;
  int pulses;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    tick();
    tick();
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_ov", 32'(bus.ov), 32'h0);
    check("rst_out_vld", 32'(bus.out_vld), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
`ifdef BABY_ALU_DROP_CNT_EN
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // add with carry out of bit 7
    drive(1'b1, OP_ADD, 8'hF0, 8'h20);
    tick();
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    check("add_out", 32'(bus.out), 32'h0110);
    check("add_ov", 32'(bus.ov), 32'h1);
    check("add_vld", 32'(bus.out_vld), 32'h1);
    tick();
    check("add_vld_pulse", 32'(bus.out_vld), 32'h0);
    check("add_out_hold", 32'(bus.out), 32'h0110);

    // sub both directions
    drive(1'b1, OP_SUB, 8'h03, 8'h05);
    tick();
    check("sub_neg_out", 32'(bus.out), 32'hFFFE);
    check("sub_neg_ov", 32'(bus.ov), 32'h1);
    drive(1'b1, OP_SUB, 8'h05, 8'h03);
    tick();
    check("sub_pos_out", 32'(bus.out), 32'h0002);
    check("sub_pos_ov", 32'(bus.ov), 32'h0);

    // unknown op while idle must do nothing
    bus.vld = 1'b0;
    bus.op  = 2'bxx;
    tick();
    tick();
    check("xop_vld", 32'(bus.out_vld), 32'h0);
    check("xop_out", 32'(bus.out), 32'h0002);

    // mul FF*FF, then back-to-back mul accepted in the OUT_VLD cycle
    drive(1'b1, OP_MUL, 8'hFF, 8'hFF);
    tick();
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    check("mul_busy", 32'(bus.busy), 32'h1);
    wait_mul(bc, ev);
    check("mul_busy_cycles", 32'(bc), 32'd8);
    check("mul_no_early_vld", 32'(ev), 32'd0);
    check("mul_ff_out", 32'(bus.out), 32'hFE01);
    check("mul_ff_ov", 32'(bus.ov), 32'h1);
    check("mul_ff_vld", 32'(bus.out_vld), 32'h1);
    drive(1'b1, OP_MUL, 8'h0F, 8'h0F);
    tick();
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    check("mul2_busy", 32'(bus.busy), 32'h1);
    wait_mul(bc, ev);
    check("mul2_busy_cycles", 32'(bc), 32'd8);
    check("mul_0f_out", 32'(bus.out), 32'h00E1);
    check("mul_0f_ov", 32'(bus.ov), 32'h0);
    check("mul_0f_vld", 32'(bus.out_vld), 32'h1);

    // three dropped requests during a mul
    drive(1'b1, OP_MUL, 8'h10, 8'h20);
    tick();
    pulses = 0;
    drive(1'b1, OP_ADD, 8'h01, 8'h01);
    for (int i = 0; i < 3; i++) begin
      if (bus.out_vld) pulses++;
      tick();
    end
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    for (int i = 0; i < 15; i++) begin
      if (bus.out_vld) pulses++;
      tick();
    end
    check("drop_pulses", 32'(pulses), 32'd1);
    check("drop_mul_out", 32'(bus.out), 32'h0200);
    check("drop_mul_ov", 32'(bus.ov), 32'h1);
`ifdef BABY_ALU_DROP_CNT_EN
    check("drop_cnt3", 32'(bus.drop_cnt), 32'd3);
    drive(1'b1, OP_MUL, 8'h01, 8'h01);
    repeat (400) tick();
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    wait_mul(bc, ev);
    check("drop_cnt_sat", 32'(bus.drop_cnt), 32'hFF);
`endif
    tick();

    // reset asserted mid-mul aborts it
    drive(1'b1, OP_MUL, 8'hFF, 8'hFF);
    tick();
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    repeat (4) tick();
    check("abort_busy_pre", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_out", 32'(bus.out), 32'h0);
    check("abort_ov", 32'(bus.ov), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_vld", 32'(bus.out_vld), 32'h0);
`ifdef BABY_ALU_DROP_CNT_EN
    check("abort_drop_cnt", 32'(bus.drop_cnt), 32'h0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_vld) pulses++;
    end
    check("abort_no_vld", 32'(pulses), 32'd0);
    check("abort_out_hold", 32'(bus.out), 32'h0);

    // back-to-back single-cycle ops
    drive(1'b1, OP_XOR, 8'hAA, 8'h0F);
    tick();
    check("b2b_xor_out", 32'(bus.out), 32'h00A5);
    check("b2b_xor_ov", 32'(bus.ov), 32'h0);
    check("b2b_xor_vld", 32'(bus.out_vld), 32'h1);
    drive(1'b1, OP_ADD, 8'h80, 8'h80);
    tick();
    check("b2b_add_out", 32'(bus.out), 32'h0100);
    check("b2b_add_ov", 32'(bus.ov), 32'h1);
    check("b2b_add_vld", 32'(bus.out_vld), 32'h1);
    drive(1'b1, OP_SUB, 8'h10, 8'h20);
    tick();
    check("b2b_sub_out", 32'(bus.out), 32'hFFF0);
    check("b2b_sub_ov", 32'(bus.ov), 32'h1);
    check("b2b_sub_vld", 32'(bus.out_vld), 32'h1);
    drive(1'b1, OP_XOR, 8'hFF, 8'hFF);
    tick();
    check("b2b_xor2_out", 32'(bus.out), 32'h0000);
    check("b2b_xor2_ov", 32'(bus.ov), 32'h0);
    check("b2b_xor2_vld", 32'(bus.out_vld), 32'h1);
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    tick();
    check("b2b_idle_vld", 32'(bus.out_vld), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
